// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-drive and response signals of the ALU op sequencer.
// The slave modport is the sequencer; the master modport is the requester/ALU side.
interface alu_op_sequencer_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [15:0] req0_a;
   logic [15:0] req0_b;
   logic [2:0]  req0_op;
   logic        req1_valid;
   logic        req1_ready;
   logic [15:0] req1_a;
   logic [15:0] req1_b;
   logic [2:0]  req1_op;
   logic [15:0] alu_din1;
   logic [15:0] alu_din2;
   logic [2:0]  alu_ms;
   logic [15:0] alu_out;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [15:0] rsp_data;
   logic        rsp_err;
   logic        busy;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      input  alu_out, rsp_ready,
      output req0_ready, req1_ready,
      output alu_din1, alu_din2, alu_ms,
      output rsp_valid, rsp_id, rsp_data, rsp_err, busy
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      output alu_out, rsp_ready,
      input  req0_ready, req1_ready,
      input  alu_din1, alu_din2, alu_ms,
      input  rsp_valid, rsp_id, rsp_data, rsp_err, busy
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Round-robin two-port front end for the shared 16-bit ALU: holds operands for
// SETTLE_CYCLES, captures ALU_out and returns it tagged with the requester ID.
module alu_op_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   alu_op_sequencer_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_MOD    = 3'b110;

   state_t      r_state;
   state_t      w_next_state;
   logic        r_last_grant;
   logic        r_id;
   logic        r_rsp_err;
   logic [15:0] r_a;
   logic [15:0] r_b;
   logic [15:0] r_rsp_data;
   logic [2:0]  r_op;
   logic [3:0]  r_count;

   logic        w_grant_vld;
   logic        w_grant_id;
   logic        w_div_zero;
   logic [15:0] w_sel_a;
   logic [15:0] w_sel_b;
   logic [2:0]  w_sel_op;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      w_grant_vld = 1'b0;
      w_grant_id  = 1'b0;
      if (r_state == S_IDLE) begin
         if (bus.req0_valid && bus.req1_valid) begin
            w_grant_vld = 1'b1;
            w_grant_id  = ~r_last_grant;
         end else if (bus.req0_valid) begin
            w_grant_vld = 1'b1;
         end else if (bus.req1_valid) begin
            w_grant_vld = 1'b1;
            w_grant_id  = 1'b1;
         end
      end
   end

   assign w_sel_a    = w_grant_id ? bus.req1_a  : bus.req0_a;
   assign w_sel_b    = w_grant_id ? bus.req1_b  : bus.req0_b;
   assign w_sel_op   = w_grant_id ? bus.req1_op : bus.req0_op;
   assign w_div_zero = ((w_sel_op == OP_DIV) || (w_sel_op == OP_MOD)) && (w_sel_b == 16'h0000);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state   = r_state;
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      bus.alu_ms     = 3'b000;
      bus.rsp_valid  = 1'b0;
      bus.busy       = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            bus.req0_ready = w_grant_vld && !w_grant_id;
            bus.req1_ready = w_grant_vld &&  w_grant_id;
            if (w_grant_vld) w_next_state = w_div_zero ? S_RESP : S_EXEC;
         end
         S_EXEC: begin
            bus.alu_ms = r_op;
            if (r_count == 4'd1) w_next_state = S_RESP;
         end
         S_RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Operands only load for commands that will reach the ALU, so Din1/Din2 keep their last EXEC values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= 1'b1;
         r_id         <= 1'b0;
         r_a          <= 16'h0000;
         r_b          <= 16'h0000;
         r_op         <= 3'b000;
         r_count      <= 4'd0;
         r_rsp_data   <= 16'h0000;
         r_rsp_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant_vld) begin
                  r_last_grant <= w_grant_id;
                  r_id         <= w_grant_id;
                  if (w_div_zero) begin
                     r_rsp_data <= 16'hFFFF;
                     r_rsp_err  <= 1'b1;
                  end else begin
                     r_a       <= w_sel_a;
                     r_b       <= w_sel_b;
                     r_op      <= w_sel_op;
                     r_count   <= LP_SETTLE;
                     r_rsp_err <= 1'b0;
                  end
               end
            end
            S_EXEC: begin
               r_count <= r_count - 4'd1;
               if (r_count == 4'd1) r_rsp_data <= bus.alu_out;
            end
            default: ;
         endcase
      end
   end

   assign bus.alu_din1 = r_a;
   assign bus.alu_din2 = r_b;
   assign bus.rsp_id   = r_id;
   assign bus.rsp_data = r_rsp_data;
   assign bus.rsp_err  = r_rsp_err;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU and a response scoreboard.
// dut1 runs SETTLE_CYCLES=1, dut3 runs SETTLE_CYCLES=3.
module tb_alu_op_sequencer;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_op_sequencer_if if1 ();
   alu_op_sequencer_if if3 ();

   alu_op_sequencer #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
   alu_op_sequencer #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

   // ALU model: 000 pass a, 001 add, 010 sub, 011 mul (low 16), 100 div, 101 xor, 110 mod, 111 or
   function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [2:0] ms);
      logic [31:0] p;
      p = {16'h0000, a} * {16'h0000, b};
      case (ms)
         3'b000: return a;
         3'b001: return a + b;
         3'b010: return a - b;
         3'b011: return p[15:0];
         3'b100: return (b == 16'h0000) ? 16'h0000 : a / b;
         3'b101: return a ^ b;
         3'b110: return (b == 16'h0000) ? 16'h0000 : a % b;
         default: return a | b;
      endcase
   endfunction

   assign if1.alu_out = alu_f(if1.alu_din1, if1.alu_din2, if1.alu_ms);
   assign if3.alu_out = alu_f(if3.alu_din1, if3.alu_din2, if3.alu_ms);

   typedef struct packed {
      logic        id;
      logic [15:0] data;
      logic        err;
   } rsp_t;

   rsp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drv0(input logic v, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
      if1.req0_valid = v;
      if1.req0_a     = a;
      if1.req0_b     = b;
      if1.req0_op    = op;
   endtask

   task automatic drv1(input logic v, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
      if1.req1_valid = v;
      if1.req1_a     = a;
      if1.req1_b     = b;
      if1.req1_op    = op;
   endtask

   task automatic push(input logic id, input logic [15:0] data, input logic err);
      rsp_t e;
      e.id   = id;
      e.data = data;
      e.err  = err;
      sb_q.push_back(e);
   endtask

   // Called just after the accept edge; counts edges (accept edge included) until rsp_valid.
   task automatic wait_rsp(input string tag, input int exp_edges);
      int   edges;
      rsp_t e;
      edges = 1;
      while (!if1.rsp_valid && edges < 40) begin
         tick();
         edges++;
      end
      check({tag, " latency"}, 32'(edges), 32'(exp_edges));
      check({tag, " rsp_valid"}, 32'(if1.rsp_valid), 32'd1);
      check({tag, " sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check({tag, " rsp_id"}, 32'(if1.rsp_id), 32'(e.id));
         check({tag, " rsp_data"}, 32'(if1.rsp_data), 32'(e.data));
         check({tag, " rsp_err"}, 32'(if1.rsp_err), 32'(e.err));
      end
   endtask

   task automatic reset_checks(input string tag);
      check({tag, " rsp_valid"}, 32'(if1.rsp_valid), 32'd0);
      check({tag, " busy"}, 32'(if1.busy), 32'd0);
      check({tag, " alu_ms"}, 32'(if1.alu_ms), 32'd0);
      check({tag, " alu_din1"}, 32'(if1.alu_din1), 32'd0);
      check({tag, " alu_din2"}, 32'(if1.alu_din2), 32'd0);
      check({tag, " rsp_id"}, 32'(if1.rsp_id), 32'd0);
      check({tag, " rsp_data"}, 32'(if1.rsp_data), 32'd0);
      check({tag, " rsp_err"}, 32'(if1.rsp_err), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      drv0(1'b0, 16'h0, 16'h0, 3'b000);
      drv1(1'b0, 16'h0, 16'h0, 3'b000);
      if1.rsp_ready  = 1'b1;
      if3.req0_valid = 1'b0;
      if3.req0_a     = 16'h0;
      if3.req0_b     = 16'h0;
      if3.req0_op    = 3'b000;
      if3.req1_valid = 1'b0;
      if3.req1_a     = 16'h0;
      if3.req1_b     = 16'h0;
      if3.req1_op    = 3'b000;
      if3.rsp_ready  = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      reset_checks("reset");
      check("idle no_ready", 32'({if1.req1_ready, if1.req0_ready}), 32'd0);

      // Single add on req0
      drv0(1'b1, 16'h0003, 16'h0004, 3'b001);
      settle();
      check("add req0_ready", 32'(if1.req0_ready), 32'd1);
      push(1'b0, 16'h0007, 1'b0);
      tick();
      drv0(1'b0, 16'h0, 16'h0, 3'b000);
      check("add exec alu_ms", 32'(if1.alu_ms), 32'h1);
      check("add exec din1", 32'(if1.alu_din1), 32'h3);
      check("add exec din2", 32'(if1.alu_din2), 32'h4);
      check("add exec busy", 32'(if1.busy), 32'd1);
      wait_rsp("add", 2);
      tick();

      // Fresh reset, then repeated ties
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drv0(1'b1, 16'd10, 16'd3, 3'b010);
      drv1(1'b1, 16'h0100, 16'h0100, 3'b011);
      settle();
      check("tie1 grants", 32'({if1.req1_ready, if1.req0_ready}), 32'b01);
      push(1'b0, 16'h0007, 1'b0);
      tick();
      drv0(1'b0, 16'h0, 16'h0, 3'b000);
      wait_rsp("tie1 sub", 2);
      check("tie1 resp req1_ready", 32'(if1.req1_ready), 32'd0);
      tick();
      check("tie1 next grants", 32'({if1.req1_ready, if1.req0_ready}), 32'b10);
      push(1'b1, 16'h0000, 1'b0);
      tick();
      drv1(1'b0, 16'h0, 16'h0, 3'b000);
      wait_rsp("tie1 mul", 2);
      tick();
      drv0(1'b1, 16'd10, 16'd3, 3'b010);
      drv1(1'b1, 16'h0100, 16'h0100, 3'b011);
      settle();
      check("tie3 grants", 32'({if1.req1_ready, if1.req0_ready}), 32'b01);
      push(1'b0, 16'h0007, 1'b0);
      tick();
      drv0(1'b0, 16'h0, 16'h0, 3'b000);
      drv1(1'b0, 16'h0, 16'h0, 3'b000);
      wait_rsp("tie3 sub", 2);
      tick();

      // Divide and modulo by zero
      drv1(1'b1, 16'h1234, 16'h0000, 3'b100);
      settle();
      check("div0 req1_ready", 32'(if1.req1_ready), 32'd1);
      push(1'b1, 16'hFFFF, 1'b1);
      tick();
      drv1(1'b0, 16'h0, 16'h0, 3'b000);
      check("div0 alu_ms", 32'(if1.alu_ms), 32'd0);
      check("div0 din1 held", 32'(if1.alu_din1), 32'd10);
      wait_rsp("div0", 1);
      tick();
      drv0(1'b1, 16'h0005, 16'h0000, 3'b110);
      settle();
      check("mod0 req0_ready", 32'(if1.req0_ready), 32'd1);
      push(1'b0, 16'hFFFF, 1'b1);
      tick();
      drv0(1'b0, 16'h0, 16'h0, 3'b000);
      check("mod0 alu_ms", 32'(if1.alu_ms), 32'd0);
      wait_rsp("mod0", 1);
      tick();

      // Backpressure on an XOR; req1 waits behind it
      if1.rsp_ready = 1'b0;
      drv0(1'b1, 16'h00FF, 16'h0F0F, 3'b101);
      settle();
      push(1'b0, 16'h0FF0, 1'b0);
      tick();
      drv0(1'b0, 16'h0, 16'h0, 3'b000);
      drv1(1'b1, 16'h0001, 16'h0001, 3'b001);
      wait_rsp("xor", 2);
      for (int i = 0; i < 5; i++) begin
         check("bp rsp_valid", 32'(if1.rsp_valid), 32'd1);
         check("bp rsp_data", 32'(if1.rsp_data), 32'h0FF0);
         check("bp ready", 32'({if1.req1_ready, if1.req0_ready}), 32'd0);
         tick();
      end
      if1.rsp_ready = 1'b1;
      settle();
      check("bp handshake ready", 32'({if1.req1_ready, if1.req0_ready}), 32'd0);
      tick();
      check("bp after ready", 32'({if1.req1_ready, if1.req0_ready}), 32'b10);
      push(1'b1, 16'h0002, 1'b0);
      tick();
      drv1(1'b0, 16'h0, 16'h0, 3'b000);
      wait_rsp("bp add", 2);
      tick();

      // SETTLE_CYCLES=3 modulo on dut3
      if3.req0_valid = 1'b1;
      if3.req0_a     = 16'd17;
      if3.req0_b     = 16'd5;
      if3.req0_op    = 3'b110;
      settle();
      check("s3 req0_ready", 32'(if3.req0_ready), 32'd1);
      tick();
      if3.req0_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("s3 exec alu_ms", 32'(if3.alu_ms), 32'h6);
         check("s3 exec din1", 32'(if3.alu_din1), 32'd17);
         check("s3 exec din2", 32'(if3.alu_din2), 32'd5);
         check("s3 exec no_valid", 32'(if3.rsp_valid), 32'd0);
         tick();
      end
      check("s3 rsp_valid", 32'(if3.rsp_valid), 32'd1);
      check("s3 rsp_data", 32'(if3.rsp_data), 32'h0002);
      check("s3 rsp_err", 32'(if3.rsp_err), 32'd0);
      check("s3 rsp_id", 32'(if3.rsp_id), 32'd0);
      check("s3 alu_ms idle", 32'(if3.alu_ms), 32'd0);
      tick();

      // Reset while in EXEC drops the command
      drv0(1'b1, 16'h0042, 16'h0001, 3'b001);
      settle();
      tick();
      drv0(1'b0, 16'h0, 16'h0, 3'b000);
      check("midrst exec alu_ms", 32'(if1.alu_ms), 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      reset_checks("midrst");
      tick();
      check("midrst no_rsp", 32'(if1.rsp_valid), 32'd0);
      drv0(1'b1, 16'hFFFF, 16'h0001, 3'b001);
      drv1(1'b1, 16'h00F0, 16'h000F, 3'b111);
      settle();
      check("midrst tie grants", 32'({if1.req1_ready, if1.req0_ready}), 32'b01);
      push(1'b0, 16'h0000, 1'b0);
      tick();
      drv0(1'b0, 16'h0, 16'h0, 3'b000);
      wait_rsp("midrst add wrap", 2);
      tick();
      check("midrst req1 grant", 32'(if1.req1_ready), 32'd1);
      push(1'b1, 16'h00FF, 1'b0);
      tick();
      drv1(1'b0, 16'h0, 16'h0, 3'b000);
      wait_rsp("midrst or", 2);
      tick();

      check("sb drained", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
